// File: rtl/riscv_pkg.sv
// Shared core types: FP register width, pipeline control and the FP write-back entry.
package riscv_pkg;

    localparam int FpWidth = 32;

    typedef struct packed {
        logic stall;
        logic flush;
    } pipeline_ctrl_t;

    typedef struct packed {
        logic [4:0]         dest;
        logic [FpWidth-1:0] data;
    } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// Small power-of-two FIFO buffering div/sqrt results until the FP write port is free.
module fp_wb_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = riscv_pkg::fp_wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   empty,
    output logic   full
);

    localparam int AW = $clog2(DEPTH);

    // The extra MSB on each pointer separates full (MSBs differ) from empty (MSBs equal).
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the reset pointers already mark every slot invalid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP register-file write-back arbiter: fixed-latency pipe has priority, div/sqrt results are
// buffered, and a per-register pending scoreboard tracks outstanding writes.
module fp_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH     = FpWidth,
    parameter int DIV_FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall,
    input  logic                  i_issue_valid,
    input  logic [4:0]            i_issue_dest,
    input  logic                  i_pipe_valid,
    input  logic [4:0]            i_pipe_dest,
    input  logic [DATA_WIDTH-1:0] i_pipe_data,
    input  logic                  i_div_valid,
    output logic                  o_div_ready,
    input  logic [4:0]            i_div_dest,
    input  logic [DATA_WIDTH-1:0] i_div_data,
    output logic                  o_wr_en,
    output logic [4:0]            o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [31:0]           o_pending
);

    logic            sample;
    logic            fifo_empty;
    logic            fifo_full;
    logic            head_drain;
    logic            div_fire;
    logic            bypass;
    fp_wb_entry_t    div_entry;
    fp_wb_entry_t    head;

    logic                  sel_en;
    logic [4:0]            sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [31:0]           set_vec;
    logic [31:0]           clr_vec;

    assign sample     = !i_stall;
    assign head_drain = sample && !i_pipe_valid && !fifo_empty;
    // A full FIFO can still accept when its head leaves in the same cycle.
    assign o_div_ready = !fifo_full || head_drain;
    assign div_fire    = i_div_valid && o_div_ready && sample;
    assign bypass      = div_fire && fifo_empty && !i_pipe_valid;
    assign div_entry   = '{dest: i_div_dest, data: i_div_data};

    fp_wb_fifo #(
        .DEPTH   (DIV_FIFO_DEPTH),
        .entry_t (fp_wb_entry_t)
    ) u_div_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (div_fire && !bypass),
        .push_data (div_entry),
        .pop       (head_drain),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel_en   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        if (i_pipe_valid) begin
            sel_en   = 1'b1;
            sel_addr = i_pipe_dest;
            sel_data = i_pipe_data;
        end else if (!fifo_empty) begin
            sel_en   = 1'b1;
            sel_addr = head.dest;
            sel_data = head.data;
        end else if (div_fire) begin
            sel_en   = 1'b1;
            sel_addr = i_div_dest;
            sel_data = i_div_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else if (sample) begin
            o_wr_en <= sel_en;
            if (sel_en) begin
                o_wr_addr <= sel_addr;
                o_wr_data <= sel_data;
            end
        end
    end

    // A write commits on the unstalled cycle it is visible on o_wr_*; a same-cycle issue re-sets the bit.
    assign set_vec = i_issue_valid ? (32'h1 << i_issue_dest) : '0;
    assign clr_vec = o_wr_en       ? (32'h1 << o_wr_addr)    : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pending <= '0;
        end else if (sample) begin
            o_pending <= (o_pending & ~clr_vec) | set_vec;
        end
    end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench for fp_wb_arbiter: directed vector table, reset scenario, then
// randomized traffic against a queue-based reference model.
module tb_fp_wb_arbiter;
    import riscv_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_stall = 1'b0;
    logic          i_issue_valid = 1'b0;
    logic [4:0]    i_issue_dest = '0;
    logic          i_pipe_valid = 1'b0;
    logic [4:0]    i_pipe_dest = '0;
    logic [DW-1:0] i_pipe_data = '0;
    logic          i_div_valid = 1'b0;
    logic          o_div_ready;
    logic [4:0]    i_div_dest = '0;
    logic [DW-1:0] i_div_data = '0;
    logic          o_wr_en;
    logic [4:0]    o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic [31:0]   o_pending;

    fp_wb_arbiter #(.DATA_WIDTH(DW), .DIV_FIFO_DEPTH(DEPTH)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_stall       (i_stall),
        .i_issue_valid (i_issue_valid),
        .i_issue_dest  (i_issue_dest),
        .i_pipe_valid  (i_pipe_valid),
        .i_pipe_dest   (i_pipe_dest),
        .i_pipe_data   (i_pipe_data),
        .i_div_valid   (i_div_valid),
        .o_div_ready   (o_div_ready),
        .i_div_dest    (i_div_dest),
        .i_div_data    (i_div_data),
        .o_wr_en       (o_wr_en),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .o_pending     (o_pending)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          stall;
        logic          iv;
        logic [4:0]    id;
        logic          pv;
        logic [4:0]    pd;
        logic [31:0]   pdata;
        logic          dv;
        logic [4:0]    dd;
        logic [31:0]   ddata;
        logic          e_ready;
        logic          e_en;
        logic [4:0]    e_addr;
        logic [31:0]   e_data;
        logic [31:0]   e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic iv, logic [4:0] id, logic pv, logic [4:0] pd,
                                logic [31:0] pdata, logic dv, logic [4:0] dd, logic [31:0] ddata,
                                logic rdy, logic en, logic [4:0] a, logic [31:0] d, logic [31:0] p);
        vec_t v;
        v.stall = st; v.iv = iv; v.id = id; v.pv = pv; v.pd = pd; v.pdata = pdata;
        v.dv = dv; v.dd = dd; v.ddata = ddata;
        v.e_ready = rdy; v.e_en = en; v.e_addr = a; v.e_data = d; v.e_pend = p;
        return v;
    endfunction

    task automatic drive(input logic st, input logic iv, input logic [4:0] id,
                         input logic pv, input logic [4:0] pd, input logic [31:0] pdata,
                         input logic dv, input logic [4:0] dd, input logic [31:0] ddata);
        i_stall = st; i_issue_valid = iv; i_issue_dest = id;
        i_pipe_valid = pv; i_pipe_dest = pd; i_pipe_data = pdata;
        i_div_valid = dv; i_div_dest = dd; i_div_data = ddata;
    endtask

    // Reference model: pending bits, a queue of buffered div results and the visible write port.
    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_pend;

    function automatic logic model_ready();
        return (q.size() < DEPTH) || (!i_stall && !i_pipe_valid);
    endfunction

    task automatic model_step();
        logic  fire;
        logic [31:0] nxt_pend;
        ent_t  e;
        if (i_stall) return;
        fire     = i_div_valid && model_ready();
        nxt_pend = m_pend;
        if (m_en) nxt_pend[m_addr] = 1'b0;
        if (i_issue_valid) nxt_pend[i_issue_dest] = 1'b1;
        m_pend = nxt_pend;
        e.dest = i_div_dest;
        e.data = i_div_data;
        if (i_pipe_valid) begin
            m_en = 1'b1; m_addr = i_pipe_dest; m_data = i_pipe_data;
            if (fire) q.push_back(e);
        end else if (q.size() > 0) begin
            ent_t h;
            h = q.pop_front();
            m_en = 1'b1; m_addr = h.dest; m_data = h.data;
            if (fire) q.push_back(e);
        end else if (fire) begin
            m_en = 1'b1; m_addr = e.dest; m_data = e.data;
        end else begin
            m_en = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t v;
        // Directed table, starting from a freshly reset block.
        //            st iv id  pv pd  pdata         dv dd  ddata         rdy en a   data          pend
        vecs.push_back(mk(0, 0, 0,  1, 5,  32'h3F800000, 0, 0,  0,            1, 1, 5,  32'h3F800000, 0));
        vecs.push_back(mk(0, 0, 0,  1, 3,  32'h40000000, 1, 7,  32'h40400000, 1, 1, 3,  32'h40000000, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0,            0, 0,  0,            1, 1, 7,  32'h40400000, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0,            1, 8,  32'h00000088, 1, 1, 8,  32'h00000088, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0,            0, 0,  0,            1, 0, 8,  32'h00000088, 0));
        vecs.push_back(mk(0, 1, 1,  1, 1,  32'h11,       1, 10, 32'hAAAA,     1, 1, 1,  32'h11,       32'h2));
        vecs.push_back(mk(0, 0, 0,  1, 2,  32'h22,       1, 11, 32'hBBBB,     1, 1, 2,  32'h22,       0));
        vecs.push_back(mk(0, 0, 0,  1, 3,  32'h33,       1, 12, 32'hCCCC,     0, 1, 3,  32'h33,       0));
        vecs.push_back(mk(0, 0, 0,  1, 4,  32'h44,       1, 12, 32'hCCCC,     0, 1, 4,  32'h44,       0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0,            1, 12, 32'hCCCC,     1, 1, 10, 32'hAAAA,     0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0,            0, 0,  0,            1, 1, 11, 32'hBBBB,     0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0,            0, 0,  0,            1, 1, 12, 32'hCCCC,     0));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0,            0, 0,  0,            1, 0, 12, 32'hCCCC,     0));
        vecs.push_back(mk(0, 1, 9,  1, 9,  32'h99,       0, 0,  0,            1, 1, 9,  32'h99,       32'h200));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 1, 20, 1, 6, 32'h66,    1, 15, 32'hFFFF,     1, 1, 9,  32'h99,       32'h200));
        vecs.push_back(mk(0, 1, 9,  0, 0,  0,            0, 0,  0,            1, 0, 9,  32'h99,       32'h200));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0,            0, 0,  0,            1, 0, 9,  32'h99,       32'h200));
        vecs.push_back(mk(0, 0, 0,  1, 9,  32'h1234,     0, 0,  0,            1, 1, 9,  32'h1234,     32'h200));
        vecs.push_back(mk(0, 0, 0,  0, 0,  0,            0, 0,  0,            1, 0, 9,  32'h1234,     0));

        // Reset state while held.
        #3;
        check("reset wr_en", {31'b0, o_wr_en}, 0);
        check("reset wr_addr", {27'b0, o_wr_addr}, 0);
        check("reset wr_data", o_wr_data, 0);
        check("reset pending", o_pending, 0);
        check("reset div_ready", {31'b0, o_div_ready}, 1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        foreach (vecs[k]) begin
            v = vecs[k];
            drive(v.stall, v.iv, v.id, v.pv, v.pd, v.pdata, v.dv, v.dd, v.ddata);
            @(negedge i_clk);
            check($sformatf("vec%0d div_ready", k), {31'b0, o_div_ready}, {31'b0, v.e_ready});
            @(posedge i_clk); #1;
            check($sformatf("vec%0d wr_en", k), {31'b0, o_wr_en}, {31'b0, v.e_en});
            check($sformatf("vec%0d wr_addr", k), {27'b0, o_wr_addr}, {27'b0, v.e_addr});
            check($sformatf("vec%0d wr_data", k), o_wr_data, v.e_data);
            check($sformatf("vec%0d pending", k), o_pending, v.e_pend);
        end

        // Fill the FIFO with two div results behind pipe traffic, then reset asynchronously.
        drive(0, 1, 4, 1, 1, 32'h1, 1, 2, 32'h2);
        @(posedge i_clk); #1;
        drive(0, 0, 0, 1, 3, 32'h3, 1, 6, 32'h6);
        @(posedge i_clk); #1;
        check("fill div_ready full", {31'b0, o_div_ready}, 0);
        check("fill pending f4", o_pending, 32'h10);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async rst wr_en", {31'b0, o_wr_en}, 0);
        check("async rst pending", o_pending, 0);
        check("async rst div_ready", {31'b0, o_div_ready}, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("post rst no buffered write", {31'b0, o_wr_en}, 0);
        @(posedge i_clk); #1;
        check("post rst still idle", {31'b0, o_wr_en}, 0);

        q.delete();
        m_en = 1'b0; m_addr = '0; m_data = '0; m_pend = '0;

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1, 5'($urandom),
                  $urandom_range(0, 2) == 0, 5'($urandom), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
            @(negedge i_clk);
            check($sformatf("rnd%0d div_ready", c), {31'b0, o_div_ready}, {31'b0, model_ready()});
            model_step();
            @(posedge i_clk); #1;
            check($sformatf("rnd%0d wr_en", c), {31'b0, o_wr_en}, {31'b0, m_en});
            check($sformatf("rnd%0d wr_addr", c), {27'b0, o_wr_addr}, {27'b0, m_addr});
            check($sformatf("rnd%0d wr_data", c), o_wr_data, m_data);
            check($sformatf("rnd%0d pending", c), o_pending, m_pend);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
